step_clk_ctrl: RTL and testbench
================================

Name: step_clk_ctrl

Overview:
- Board-level clock controller that drives the CPU core clock in the visual top level; replaces the free-running 1 Hz divider.
- Debounces two push-buttons (run/stop toggle, single step) from the 50 MHz board clock.
- Produces a registered, glitch-free CPU clock: free-running at a programmable rate, halted low, or one full period per step press.
- Also provides a one-cycle tick pulse and status LEDs.

Parameters:
- DIV, 25000000, board-clock cycles per CPU clock half-period (default gives 1 Hz from 50 MHz); DIV >= 2.
- DB_CYCLES, 500000, board-clock cycles an input must stay stable before it is accepted (10 ms); DB_CYCLES >= 2.
- CNT_W, 25, width of the divider and debounce counters; must hold DIV-1 and DB_CYCLES-1.
- WIDTH, 8, width of the optional cycle counter.

Ports:
- clk  in  1  50 MHz board clock.
- rst  in  1  synchronous, active-high reset.
- run_btn  in  1  raw run/stop button, active-high, asynchronous to clk.
- step_btn  in  1  raw step button, active-high, asynchronous to clk.
- cpu_clk  out  1  registered CPU clock.
- tick  out  1  one clk-cycle pulse, coincident with the cycle cpu_clk goes 0->1.
- running  out  1  high in RUN and DRAIN.
- halted  out  1  high in STOP only.

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset values: state=STOP, cpu_clk=0, tick=0, running=0, halted=1. Debounced levels=0, all counters=0.
- Reset mid-operation, including mid-step or mid-drain: all outputs return to reset values on the next clk edge.
- Input synchronisers: each button passes through a 2-FF synchroniser.
- Debounce:
  - Per button, a counter clears whenever the synchronised input equals the stable level.
  - Otherwise it increments. When it reaches DB_CYCLES-1, the stable level takes the new value and the counter clears.
  - A press is a single-cycle pulse on a 0->1 transition of the stable level.
  - Latency from a raw edge to the press pulse = 2 + DB_CYCLES clk cycles.
  - Bounces shorter than DB_CYCLES produce no press.
- Divider:
  - Counts 0..DIV-1 while in RUN, DRAIN or STEP_HI. At DIV-1 it wraps to 0 and marks a half-period boundary.
  - Cleared to 0 on entry to RUN or STEP_HI.
- FSM states and transitions:
  - STOP: cpu_clk held 0. run press -> RUN. step press -> STEP_HI, with cpu_clk=1 and tick=1 in the same cycle the registers update.
  - RUN: cpu_clk toggles at each boundary; tick asserts on the 0->1 toggles. run press -> DRAIN if cpu_clk=1, else -> STOP.
  - DRAIN: continues until the next boundary, then cpu_clk=0 -> STOP. No new rising edge occurs.
  - STEP_HI: cpu_clk=1 for exactly DIV clk cycles, then cpu_clk=0 -> STOP.
- Ignored events:
  - step press in RUN, DRAIN or STEP_HI is ignored.
  - run press in DRAIN or STEP_HI is ignored.
- Simultaneous run and step press in STOP: run wins, next state RUN.
- The first rising edge after entering RUN occurs DIV cycles after entry; cpu_clk is 0 on entry.
- Every cpu_clk high and low phase is exactly DIV clk cycles, except the low phase spanning STOP.
- All outputs are registered; no combinational path from button inputs to outputs.

Optional Feature:
- Macro: CYCLE_CNT_EN.
- When defined, adds output port cycle_cnt (out, WIDTH bits): counts tick pulses, wraps from 2^WIDTH-1 to 0, and is cleared by rst.
- Used for a board LED/display of executed instruction count.
- When undefined, the port and counter are absent and behaviour is otherwise identical.

Test Plan (DIV=4, DB_CYCLES=3):
- Reset, then hold buttons low 100 cycles -> cpu_clk=0, halted=1, running=0, tick never asserts.
- run_btn high for 10 cycles -> press registered 5 cycles after the raw edge, running=1. cpu_clk first rises 4 cycles after RUN entry, then toggles every 4 cycles. tick is high exactly on each rising edge.
- In STOP, step_btn press -> cpu_clk high for exactly 4 cycles then low, one tick, state back to STOP. A second step press during the high phase adds no extra edge.
- In RUN with cpu_clk=1, run press -> DRAIN, then cpu_clk falls at the next boundary and halted=1. Pulse count equals the rising edges observed.
- run_btn glitch pattern 1,0,1,0 (1 cycle each) -> no press, state unchanged.
- With CYCLE_CNT_EN and WIDTH=8: 256 steps -> cycle_cnt wraps to 0. Assert rst mid-STEP_HI -> cpu_clk=0 and cycle_cnt=0 next cycle.

Source files
------------

// File: rtl/step_clk_ctrl.sv
// step_clk_ctrl: board-level CPU clock controller.
// Two debounced push-buttons (run/stop toggle, single step) steer a
// registered, glitch-free CPU clock: free-running at DIV board cycles per
// half-period, halted low, or one full period per step press.
// Optional feature macro: CYCLE_CNT_EN adds the cycle_cnt output, a
// WIDTH-bit wrapping count of tick pulses.
//
// Handshake note: the block has no valid/ready interfaces. The button inputs
// are raw asynchronous levels, and every output is a plain registered level
// or a single-cycle pulse (tick).
module step_clk_ctrl #(
    parameter int DIV       = 25000000,
    parameter int DB_CYCLES = 500000,
    parameter int CNT_W     = 25,
    parameter int WIDTH     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run_btn,
    input  logic             step_btn,
    output logic             cpu_clk,
    output logic             tick,
    output logic             running,
    output logic             halted
`ifdef CYCLE_CNT_EN
    ,
    output logic [WIDTH-1:0] cycle_cnt
`endif
);

    typedef enum logic [1:0] {
        STOP    = 2'd0,
        RUN     = 2'd1,
        DRAIN   = 2'd2,
        STEP_HI = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DB_CYCLES - 1);

    // Bit 0 is the run/stop button, bit 1 the step button.
    logic [1:0]       btn_raw;
    logic [1:0]       sync1;
    logic [1:0]       sync2;
    logic [1:0]       stable;
    logic [1:0]       press;
    logic [CNT_W-1:0] db_cnt [2];

    logic             run_press;
    logic             step_press;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] div_cnt;
    logic [CNT_W-1:0] div_nxt;
    logic             boundary;
    logic             cpu_clk_nxt;
    logic             tick_nxt;
    logic             running_nxt;
    logic             halted_nxt;

    assign btn_raw = {step_btn, run_btn};

    // Two-flop synchronisers followed by a per-button stability counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1  <= '0;
            sync2  <= '0;
            stable <= '0;
            for (int i = 0; i < 2; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            sync1 <= btn_raw;
            sync2 <= sync1;
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == stable[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    stable[i] <= sync2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    // A press is the single cycle in which the stable level is accepted as 1.
    always_comb begin
        press = '0;
        for (int i = 0; i < 2; i++) begin
            press[i] = sync2[i] && !stable[i] && (db_cnt[i] == DB_LAST);
        end
    end

    assign run_press  = press[0];
    assign step_press = press[1];

    // Half-period boundary: only meaningful while the divider is counting.
    assign boundary = (div_cnt == DIV_LAST);

    // State, divider and all outputs are registered together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= STOP;
            div_cnt <= '0;
            cpu_clk <= 1'b0;
            tick    <= 1'b0;
            running <= 1'b0;
            halted  <= 1'b1;
        end else begin
            state   <= state_nxt;
            div_cnt <= div_nxt;
            cpu_clk <= cpu_clk_nxt;
            tick    <= tick_nxt;
            running <= running_nxt;
            halted  <= halted_nxt;
        end
    end

    // Next-state, divider and output decode.
    always_comb begin
        state_nxt   = state;
        div_nxt     = div_cnt;
        cpu_clk_nxt = cpu_clk;
        tick_nxt    = 1'b0;

        case (state)
            STOP: begin
                // Divider parks at 0 so RUN/STEP_HI always start a full phase.
                div_nxt     = '0;
                cpu_clk_nxt = 1'b0;
                if (run_press) begin
                    state_nxt = RUN;
                end else if (step_press) begin
                    state_nxt   = STEP_HI;
                    cpu_clk_nxt = 1'b1;
                    tick_nxt    = 1'b1;
                end
            end

            RUN: begin
                div_nxt = boundary ? '0 : div_cnt + CNT_W'(1);
                if (run_press) begin
                    // Stop takes priority over a coincident boundary so no
                    // fresh rising edge is launched; a high phase that ends
                    // on this very boundary falls now instead of draining.
                    if (cpu_clk && !boundary) begin
                        state_nxt = DRAIN;
                    end else begin
                        state_nxt   = STOP;
                        cpu_clk_nxt = 1'b0;
                    end
                end else if (boundary) begin
                    cpu_clk_nxt = !cpu_clk;
                    tick_nxt    = !cpu_clk;
                end
            end

            DRAIN: begin
                // Finish the current high phase, then park low.
                div_nxt = boundary ? '0 : div_cnt + CNT_W'(1);
                if (boundary) begin
                    state_nxt   = STOP;
                    cpu_clk_nxt = 1'b0;
                end
            end

            STEP_HI: begin
                div_nxt = boundary ? '0 : div_cnt + CNT_W'(1);
                if (boundary) begin
                    state_nxt   = STOP;
                    cpu_clk_nxt = 1'b0;
                end
            end

            default: begin
                state_nxt   = STOP;
                div_nxt     = '0;
                cpu_clk_nxt = 1'b0;
            end
        endcase

        running_nxt = (state_nxt == RUN) || (state_nxt == DRAIN);
        halted_nxt  = (state_nxt == STOP);
    end

`ifdef CYCLE_CNT_EN
    // Count executed CPU cycles, one per tick, wrapping naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_cnt <= '0;
        end else if (tick) begin
            cycle_cnt <= cycle_cnt + WIDTH'(1);
        end
    end
`else
    logic [WIDTH-1:0] unused_cycle_cnt;
    assign unused_cycle_cnt = '0;
`endif

endmodule

// File: tb/tb_step_clk_ctrl.sv
// Directed bench for step_clk_ctrl with DIV=4, DB_CYCLES=3.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_step_clk_ctrl;

    localparam int DIV       = 4;
    localparam int DB_CYCLES = 3;
    localparam int CNT_W     = 4;
    localparam int WIDTH     = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             run_btn;
    logic             step_btn;
    logic             cpu_clk;
    logic             tick;
    logic             running;
    logic             halted;
`ifdef CYCLE_CNT_EN
    logic [WIDTH-1:0] cycle_cnt;
`endif

    int          checks = 0;
    int          errors = 0;
    int          rises  = 0;
    int          ticks  = 0;
    logic        prev_cpu = 1'b0;
    logic [1:0]  exp_q[$];

    step_clk_ctrl #(
        .DIV       (DIV),
        .DB_CYCLES (DB_CYCLES),
        .CNT_W     (CNT_W),
        .WIDTH     (WIDTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .run_btn   (run_btn),
        .step_btn  (step_btn),
        .cpu_clk   (cpu_clk),
        .tick      (tick),
        .running   (running),
        .halted    (halted)
`ifdef CYCLE_CNT_EN
        ,
        .cycle_cnt (cycle_cnt)
`endif
    );

    // Clock
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Advance one clock; tick must coincide with every 0->1 of cpu_clk.
    task automatic cycle();
        @(posedge clk);
        #1;
        check("tick_on_rise", 32'(tick), 32'(cpu_clk & ~prev_cpu));
        if (cpu_clk && !prev_cpu) rises++;
        if (tick) ticks++;
        prev_cpu = cpu_clk;
    endtask

    task automatic cycles(input int n);
        repeat (n) cycle();
    endtask

    task automatic expect_state(input string tag, input logic c, input logic r, input logic h);
        check({tag, ".cpu_clk"}, 32'(cpu_clk), 32'(c));
        check({tag, ".running"}, 32'(running), 32'(r));
        check({tag, ".halted"},  32'(halted),  32'(h));
    endtask

    initial begin
        logic [1:0] exp_v;

        // Reset block
        rst      = 1'b1;
        run_btn  = 1'b0;
        step_btn = 1'b0;
        cycles(3);
        expect_state("reset", 1'b0, 1'b0, 1'b1);
        check("reset.tick", 32'(tick), 32'd0);
        rst = 1'b0;

        // Idle: nothing moves for 100 cycles.
        rises = 0; ticks = 0;
        cycles(100);
        expect_state("idle", 1'b0, 1'b0, 1'b1);
        check("idle.ticks", 32'(ticks), 32'd0);

        // Run press: accepted on the 5th edge after the raw edge.
        run_btn = 1'b1;
        cycles(4);
        check("run_lat_early", 32'(running), 32'd0);
        cycles(1);
        expect_state("run_entry", 1'b0, 1'b1, 1'b0);

        // Expected {tick, cpu_clk} for 16 cycles after RUN entry:
        // rises at +4 and +12, falls at +8 and +16.
        for (int i = 1; i <= 16; i++) begin
            exp_q.push_back({(i % 8) == 4, ((i / 4) % 2) == 1});
        end
        for (int i = 1; i <= 16; i++) begin
            cycle();
            if (i == 1) step_btn = 1'b1;   // step press lands mid-RUN: ignored
            if (i == 5) run_btn  = 1'b0;   // run held for 10 cycles total
            if (i == 8) step_btn = 1'b0;
            exp_v = exp_q.pop_front();
            check("run_wave", 32'({tick, cpu_clk}), 32'(exp_v));
        end

        // Run press while cpu_clk is high -> DRAIN, falls on next boundary.
        run_btn = 1'b1;
        cycles(4);
        expect_state("drain_pre", 1'b1, 1'b1, 1'b0);
        check("drain_pre.tick", 32'(tick), 32'd1);
        cycles(1);
        expect_state("drain", 1'b1, 1'b1, 1'b0);
        run_btn = 1'b0;
        cycles(2);
        expect_state("drain_hold", 1'b1, 1'b1, 1'b0);
        cycles(1);
        expect_state("drain_stop", 1'b0, 1'b0, 1'b1);
        check("run.rises", 32'(rises), 32'd3);
        check("run.ticks", 32'(ticks), 32'd3);
        cycles(10);
        check("post_drain.rises", 32'(rises), 32'd3);
        expect_state("post_drain", 1'b0, 1'b0, 1'b1);

        // Single step: high for exactly DIV cycles; a glitch on the
        // button during the high phase adds nothing.
        rises = 0; ticks = 0;
        step_btn = 1'b1;
        cycles(4);
        expect_state("step_early", 1'b0, 1'b0, 1'b1);
        cycles(1);
        expect_state("step_hi", 1'b1, 1'b0, 1'b0);
        check("step_hi.tick", 32'(tick), 32'd1);
        step_btn = 1'b0;
        cycles(1);
        step_btn = 1'b1;
        cycles(1);
        step_btn = 1'b0;
        cycles(1);
        expect_state("step_hold", 1'b1, 1'b0, 1'b0);
        cycles(1);
        expect_state("step_end", 1'b0, 1'b0, 1'b1);
        cycles(12);
        check("step.rises", 32'(rises), 32'd1);
        check("step.ticks", 32'(ticks), 32'd1);
        expect_state("step_idle", 1'b0, 1'b0, 1'b1);

        // Run button glitch 1,0,1,0: shorter than DB_CYCLES, no press.
        rises = 0;
        run_btn = 1'b1; cycles(1);
        run_btn = 1'b0; cycles(1);
        run_btn = 1'b1; cycles(1);
        run_btn = 1'b0; cycles(12);
        expect_state("glitch", 1'b0, 1'b0, 1'b1);
        check("glitch.rises", 32'(rises), 32'd0);

        // Simultaneous run and step press in STOP: run wins.
        rises = 0;
        run_btn = 1'b1; step_btn = 1'b1;
        cycles(4);
        expect_state("both_early", 1'b0, 1'b0, 1'b1);
        cycles(1);
        expect_state("both_run", 1'b0, 1'b1, 1'b0);
        run_btn = 1'b0; step_btn = 1'b0;
        cycles(4);
        expect_state("both_rise", 1'b1, 1'b1, 1'b0);
        cycles(1);
        // Run press with cpu_clk low stops immediately.
        run_btn = 1'b1;
        cycles(4);
        expect_state("run_low_pre", 1'b0, 1'b1, 1'b0);
        cycles(1);
        expect_state("run_low_stop", 1'b0, 1'b0, 1'b1);
        run_btn = 1'b0;
        cycles(10);
        check("both.rises", 32'(rises), 32'd1);
        expect_state("both_idle", 1'b0, 1'b0, 1'b1);

        // 256 single steps from a fresh reset.
        rst = 1'b1; cycles(1); rst = 1'b0;
        rises = 0; ticks = 0;
        for (int n = 1; n <= 256; n++) begin
            step_btn = 1'b1;
            cycles(4);
            step_btn = 1'b0;
            cycles(8);
`ifdef CYCLE_CNT_EN
            if (n == 255) check("cycle_cnt_255", 32'(cycle_cnt), 32'd255);
`endif
        end
        check("steps.rises", 32'(rises), 32'd256);
        check("steps.ticks", 32'(ticks), 32'd256);
`ifdef CYCLE_CNT_EN
        check("cycle_cnt_wrap", 32'(cycle_cnt), 32'd0);
`endif

        // Reset in the middle of a STEP_HI phase.
        step_btn = 1'b1;
        cycles(5);
        expect_state("pre_rst_step", 1'b1, 1'b0, 1'b0);
        cycles(1);
`ifdef CYCLE_CNT_EN
        check("pre_rst.cycle_cnt", 32'(cycle_cnt), 32'd1);
`endif
        rst = 1'b1;
        cycles(1);
        expect_state("rst_mid", 1'b0, 1'b0, 1'b1);
        check("rst_mid.tick", 32'(tick), 32'd0);
`ifdef CYCLE_CNT_EN
        check("rst_mid.cycle_cnt", 32'(cycle_cnt), 32'd0);
`endif
        rst = 1'b0;
        step_btn = 1'b0;
        cycles(10);
        expect_state("after_rst", 1'b0, 1'b0, 1'b1);

        // Final report
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
